// File: rtl/hps_ext_pkg.sv
// -----------------------------------------------------------------------------
// hps_ext_pkg
//   Shared constants for the HPS extension-bus register block.
//   - Command offsets relative to CMD_BASE (the block owns four codes).
//   - Byte counter width and its saturation value.
//   - Event counter width.
//   - cmd_offset(): distance of a command code from the window base.
//     The subtraction wraps, so any code below the base lands far above 3.
// -----------------------------------------------------------------------------
package hps_ext_pkg;

    localparam int BCNT_W = 5;
    localparam logic [BCNT_W-1:0] BCNT_MAX = 5'd31;

    localparam int EVT_W = 8;

    localparam logic [15:0] OFS_GET_STATUS = 16'd0;
    localparam logic [15:0] OFS_GET_CTRL   = 16'd1;
    localparam logic [15:0] OFS_SET_CTRL   = 16'd2;
    localparam logic [15:0] OFS_PULSE      = 16'd3;
    localparam logic [15:0] N_CMDS         = 16'd4;

    function automatic logic [15:0] cmd_offset(input logic [15:0] code,
                                               input logic [15:0] base);
        return code - base;
    endfunction

endpackage

// File: rtl/hps_ext_evt_cnt.sv
// -----------------------------------------------------------------------------
// hps_ext_evt_cnt
//   Counts edges of a level-toggle event line. Every change of evt_toggle
//   (rising or falling) is one event. The count is EVT_W bits and wraps.
//
// Ports
//   clk_sys     in   system clock
//   reset_n     in   asynchronous active-low reset
//   evt_toggle  in   event toggle, synchronous to clk_sys
//   evt_cnt     out  wrapping event count
// -----------------------------------------------------------------------------
module hps_ext_evt_cnt
    import hps_ext_pkg::*;
(
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             evt_toggle,
    output logic [EVT_W-1:0] evt_cnt
);

    logic toggle_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            toggle_q <= 1'b0;
            evt_cnt  <= '0;
        end else begin
            toggle_q <= evt_toggle;
            // Wrap 255 -> 0 falls out of the natural 8-bit overflow.
            if (evt_toggle != toggle_q)
                evt_cnt <= evt_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hps_ext_regs.sv
// -----------------------------------------------------------------------------
// hps_ext_regs
//   HPS extension-bus register block. Decodes the command window
//   CMD_BASE..CMD_BASE+3 on EXT_BUS and serves:
//     +0 GET_STATUS : coherent snapshot of N_STAT status words (+ checksum word)
//     +1 GET_CTRL   : read back the sticky control bits
//     +2 SET_CTRL   : write the sticky control bits
//     +3 PULSE      : one-cycle pulses on ctrl_pulse
//   Word 0 of every owned command returns {VERSION, evt_cnt}.
//
//   Optional feature macro: HPS_EXT_CSUM_EN
//     defined   -> word N_STAT+1 of GET_STATUS is the XOR of the words 1..N_STAT
//     undefined -> that word returns 0 and no checksum register exists
//
// Ports
//   clk_sys     in     system clock
//   reset_n     in     asynchronous active-low reset
//   EXT_BUS     inout  [15:0] io_dout (out), [31:16] io_din, [32] dout_en (out),
//                      [33] io_strobe, [34] io_enable, [35] unused
//   evt_toggle  in     event toggle (each edge = one event)
//   stat_in     in     N_STAT status words, word k at [16k+15:16k]
//   ctrl_clr    in     per-channel clear of ctrl_q
//   ctrl_q      out    sticky control bits
//   ctrl_pulse  out    one-cycle command pulses
// -----------------------------------------------------------------------------
module hps_ext_regs
    import hps_ext_pkg::*;
#(
    parameter logic [15:0] CMD_BASE = 16'hf0,
    parameter int          N_STAT   = 8,
    parameter int          N_CTRL   = 4,
    parameter logic [7:0]  VERSION  = 8'h01
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    inout  wire  [35:0]           EXT_BUS,
    input  logic                  evt_toggle,
    input  logic [16*N_STAT-1:0]  stat_in,
    input  logic [N_CTRL-1:0]     ctrl_clr,
    output logic [N_CTRL-1:0]     ctrl_q,
    output logic [N_CTRL-1:0]     ctrl_pulse
);

    // ------------------------------------------------------------------
    // Bus breakout
    // ------------------------------------------------------------------
    logic [15:0] io_din;
    logic        io_strobe;
    logic        io_enable;
    logic [15:0] io_dout;
    logic        dout_en;

    assign io_din    = EXT_BUS[31:16];
    assign io_strobe = EXT_BUS[33];
    assign io_enable = EXT_BUS[34];

    assign EXT_BUS[15:0] = io_dout;
    assign EXT_BUS[32]   = dout_en;

    wire unused_ext_bit = EXT_BUS[35];

    // ------------------------------------------------------------------
    // Event counter
    // ------------------------------------------------------------------
    logic [EVT_W-1:0] evt_cnt;

    hps_ext_evt_cnt u_evt_cnt (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .evt_toggle (evt_toggle),
        .evt_cnt    (evt_cnt)
    );

    // ------------------------------------------------------------------
    // Transaction state
    // ------------------------------------------------------------------
    logic [BCNT_W-1:0]      byte_cnt;
    logic [15:0]            cmd;
    logic [N_STAT-1:0][15:0] snap;

    logic [15:0] din_ofs;      // offset of the word on the bus (command decode)
    logic [15:0] cmd_ofs;      // offset of the latched command
    logic        din_in_rng;
    logic        cmd_stb;      // strobe of the command word
    logic        data_stb;     // strobe of a data word of an owned command
    logic        first_data;   // data strobe at byte_cnt=1
    logic        snap_ld;
    logic        stat_hit;     // byte_cnt addresses a snapshot word
    logic        csum_slot;    // byte_cnt addresses the checksum word
    logic [15:0] stat_word;
    logic [15:0] csum_word;
    logic        set_wr;
    logic        pulse_wr;

    always_comb begin
        din_ofs    = cmd_offset(io_din, CMD_BASE);
        cmd_ofs    = cmd_offset(cmd, CMD_BASE);
        din_in_rng = din_ofs < N_CMDS;

        cmd_stb    = io_enable && io_strobe && (byte_cnt == '0);
        // Once the command is known to be foreign (dout_en=0) every later
        // strobe of this transaction is ignored apart from the counter.
        data_stb   = io_enable && io_strobe && (byte_cnt != '0) && dout_en;
        first_data = data_stb && (byte_cnt == BCNT_W'(1));

        snap_ld    = cmd_stb && (din_ofs == OFS_GET_STATUS);
        set_wr     = first_data && (cmd_ofs == OFS_SET_CTRL);
        pulse_wr   = first_data && (cmd_ofs == OFS_PULSE);

        stat_hit   = (byte_cnt != '0) && (byte_cnt <= BCNT_W'(N_STAT));
        csum_slot  = (byte_cnt == BCNT_W'(N_STAT + 1));

        // Mux by compare rather than by index so byte_cnt values past
        // N_STAT never form an out-of-range select.
        stat_word = 16'h0000;
        for (int k = 0; k < N_STAT; k++) begin
            if (byte_cnt == BCNT_W'(k + 1))
                stat_word = snap[k];
        end
    end

    // ------------------------------------------------------------------
    // Snapshot: captured on the command edge so one GET_STATUS reads a
    // single cycle's worth of stat_in, no matter how long HPS takes.
    // Kept across transactions; only a new GET_STATUS replaces it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)
            snap <= '0;
        else if (snap_ld)
            snap <= stat_in;
    end

    // ------------------------------------------------------------------
    // Optional checksum: running XOR of the words actually driven, so it
    // matches what HPS saw even though the snapshot is static.
    // ------------------------------------------------------------------
`ifdef HPS_EXT_CSUM_EN
    logic [15:0] csum;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)
            csum <= 16'h0000;
        else if (snap_ld)
            csum <= 16'h0000;
        else if (data_stb && (cmd_ofs == OFS_GET_STATUS) && stat_hit)
            csum <= csum ^ stat_word;
    end

    assign csum_word = csum;
`else
    assign csum_word = 16'h0000;
`endif

    // ------------------------------------------------------------------
    // Framing and read data
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            byte_cnt <= '0;
            cmd      <= 16'h0000;
            dout_en  <= 1'b0;
            io_dout  <= 16'h0000;
        end else if (!io_enable) begin
            byte_cnt <= '0;
            cmd      <= 16'h0000;
            dout_en  <= 1'b0;
            io_dout  <= 16'h0000;
        end else if (io_strobe) begin
            if (byte_cnt != BCNT_MAX)
                byte_cnt <= byte_cnt + 1'b1;

            if (byte_cnt == '0) begin
                cmd     <= io_din;
                dout_en <= din_in_rng;
                io_dout <= din_in_rng ? {VERSION, evt_cnt} : 16'h0000;
            end else if (dout_en) begin
                if (cmd_ofs == OFS_GET_STATUS) begin
                    if (stat_hit)
                        io_dout <= stat_word;
                    else if (csum_slot)
                        io_dout <= csum_word;
                    else
                        io_dout <= 16'h0000;
                end else if (cmd_ofs == OFS_GET_CTRL) begin
                    io_dout <= (byte_cnt == BCNT_W'(1)) ? 16'(ctrl_q) : 16'h0000;
                end else begin
                    io_dout <= 16'h0000;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Control bits. An HPS write replaces every bit, which also makes it
    // win over a core-side clear arriving on the same edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q     <= '0;
            ctrl_pulse <= '0;
        end else begin
            ctrl_pulse <= pulse_wr ? io_din[N_CTRL-1:0] : '0;
            if (set_wr)
                ctrl_q <= io_din[N_CTRL-1:0];
            else
                ctrl_q <= ctrl_q & ~ctrl_clr;
        end
    end

endmodule
